sfx_scheduler: RTL and testbench
================================

SFX_SCHEDULER -- requirements
Module: sfx_scheduler

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 8, setting the duty width; the duty output is BIT_WIDTH+1 bits and feeds a PWM generator.
REQ-002 The block SHALL have parameter PRESCALE, default 1024, giving clock cycles per length tick; legal range is 1 or more.
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-005 The block SHALL have port sfx_trig, input, 4 bits, carrying one-cycle trigger pulses per effect; index 0 is highest priority.
REQ-006 The block SHALL have port cfg_half_period, input, 64 bits, holding a 16-bit tone half-period in clk cycles per effect; effect i occupies bits [16i+15:16i].
REQ-007 The block SHALL have port cfg_len, input, 32 bits, holding an 8-bit effect length in ticks per effect; effect i occupies bits [8i+7:8i].
REQ-008 The block SHALL have port cfg_volume, input, 32 bits, holding an 8-bit amplitude per effect; effect i occupies bits [8i+7:8i].
REQ-009 The block SHALL have port duty, output, BIT_WIDTH+1 bits, the PWM duty value.
REQ-010 The block SHALL have port active, output, 1 bit, high while an effect is playing.
REQ-011 The block SHALL have port cur_id, output, 2 bits, the index of the playing effect, valid while active is high.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle pulse when an effect completes naturally.

Function
REQ-013 The block SHALL keep a 4-bit pending register; a high sfx_trig[i] at a clock edge SHALL set pend[i].
REQ-014 If a set and a clear of the same pend bit occur at one edge, the set SHALL win.
REQ-015 The state machine SHALL have two states, IDLE and PLAY.
REQ-016 In IDLE with pend nonzero, the block SHALL at the next edge grant the lowest set index g, clear pend[g], and latch half_period, len and volume of g.
REQ-017 In IDLE, if the latched len is 0, the block SHALL discard the grant: stay in IDLE, no done pulse.
REQ-018 Otherwise the block SHALL enter PLAY with phase=1 and the half-period counter and prescaler reloaded.
REQ-019 Latency SHALL be: trig asserted before edge k, PLAY entered at edge k+1, duty=volume from edge k+1.
REQ-020 In PLAY, the output SHALL be a square wave: duty = phase ? {1'b0, volume} : 0, zero-extended to BIT_WIDTH+1 bits.
REQ-021 phase SHALL toggle every half_period cycles, so each level lasts exactly half_period cycles.
REQ-022 If half_period is 0, duty SHALL stay 0 for the whole effect, while the length still counts.
REQ-023 The prescaler SHALL count PRESCALE cycles per tick, and the length counter SHALL decrement per tick.
REQ-024 The block SHALL leave PLAY at the edge ending cycle len*PRESCALE after entry, so the effect lasts exactly len*PRESCALE cycles.
REQ-025 On natural completion, the block SHALL set active=0 and duty=0, and pulse done high for exactly one cycle after the exit edge.
REQ-026 In PLAY, if any pend[j] with j < cur_id is set, the block SHALL at the next edge preempt: grant the lowest such j as in REQ-016, reload all counters, discard the old effect without resuming it, and not pulse done.
REQ-027 In PLAY, sfx_trig[cur_id] SHALL restart the current effect at the next edge: reload all counters, phase=1, pend[cur_id] left clear.
REQ-028 In PLAY, pending effects of lower priority SHALL wait; after completion the block SHALL pass through one IDLE cycle before granting the next.
REQ-029 cfg_* inputs SHALL be sampled only at grant or restart; changes during PLAY SHALL have no effect.
REQ-030 Counter wrap-around SHALL NOT occur: all counters reload and never underflow past 0.

Reset
REQ-031 While rst is high, and immediately on its assertion regardless of clk, the block SHALL force: state=IDLE, pend=0, phase=0, all counters 0, duty=0, active=0, cur_id=0, done=0.
REQ-032 Reset asserted mid-effect SHALL abort the effect without a done pulse.
REQ-033 Triggers presented while rst is high SHALL be ignored.

Verification
REQ-034 Basic: PRESCALE=4, effect 2 with hp=3, len=2, vol=200; trig[2] -> duty 200,200,200,0,0,0,200,200 from edge k+1; active for 8 cycles; done pulse after; cur_id=2.
REQ-035 Preempt: effect 3 playing (len=10) and trig[0] with len=1 -> cur_id=0 after next edge, no done for effect 3, done after PRESCALE cycles of effect 0.
REQ-036 Queue and simultaneous: trig=4'b1010 in one cycle -> effect 1 plays first, one IDLE cycle, then effect 3; two done pulses.
REQ-037 Corners: len=0 request -> no active, no done, pend cleared; hp=0 -> duty 0 with active high for len*PRESCALE cycles.
REQ-038 Restart: trig[cur_id] halfway through -> counters reload, total active time = half elapsed + full length.
REQ-039 Async reset: rst pulse between clk edges mid-effect -> duty=0 and active=0 immediately, no done; pend cleared.

Source files
------------

// File: rtl/sfx_scheduler.sv
// Four-slot sound-effect scheduler: latches triggers, grants the highest-priority pending effect and
// plays it as a gated square wave for len*PRESCALE cycles, emitting a PWM duty value.
module sfx_scheduler #(
   parameter int BIT_WIDTH = 8,
   parameter int PRESCALE  = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           sfx_trig,
   input  logic [63:0]          cfg_half_period,
   input  logic [31:0]          cfg_len,
   input  logic [31:0]          cfg_volume,
   output logic [BIT_WIDTH:0]   duty,
   output logic                 active,
   output logic [1:0]           cur_id,
   output logic                 done
);

   localparam int PW = $clog2(PRESCALE + 1);
   localparam logic [PW-1:0] PRE_LOAD = PW'(PRESCALE);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] PLAY = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [3:0]    pend_q, pend_d;
   logic [1:0]    id_q;
   logic [15:0]   hp_q;
   logic [7:0]    vol_q;
   logic [15:0]   hp_cnt_q;
   logic [7:0]    len_cnt_q;
   logic [PW-1:0] pre_cnt_q;
   logic          phase_q;
   logic          done_q, done_d;

   logic [3:0]    pend_clr;
   logic [3:0]    trig_mask;
   logic [3:0]    pend_hi;
   logic          load;
   logic [1:0]    sel;
   logic [15:0]   sel_hp;
   logic [7:0]    sel_len;
   logic [7:0]    sel_vol;

   function automatic logic [1:0] lowest(input logic [3:0] v);
      if (v[0])      return 2'd0;
      else if (v[1]) return 2'd1;
      else if (v[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   // Only effects strictly more important than the playing one may preempt it.
   assign pend_hi = pend_q & ((4'b0001 << id_q) - 4'd1);

   always_comb begin
      state_d   = state_q;
      pend_clr  = 4'b0000;
      trig_mask = 4'b1111;
      load      = 1'b0;
      sel       = id_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pend_q != 4'b0000) begin
               sel           = lowest(pend_q);
               pend_clr[sel] = 1'b1;
               if (cfg_len[{sel, 3'b000} +: 8] != 8'd0) begin
                  load    = 1'b1;
                  state_d = PLAY;
               end
            end
         end
         PLAY: begin
            if (pend_hi != 4'b0000) begin
               sel           = lowest(pend_hi);
               pend_clr[sel] = 1'b1;
               if (cfg_len[{sel, 3'b000} +: 8] != 8'd0) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (sfx_trig[id_q]) begin
               load            = 1'b1;
               trig_mask[id_q] = 1'b0;
            end else if (len_cnt_q == 8'd1 && pre_cnt_q == PW'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Clear first, then set, so a trigger coinciding with a grant stays pending.
      pend_d = (pend_q & ~pend_clr) | (sfx_trig & trig_mask);
   end

   assign sel_hp  = cfg_half_period[{sel, 4'b0000} +: 16];
   assign sel_len = cfg_len[{sel, 3'b000} +: 8];
   assign sel_vol = cfg_volume[{sel, 3'b000} +: 8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= 4'b0000;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_q      <= 2'd0;
         hp_q      <= 16'd0;
         vol_q     <= 8'd0;
         hp_cnt_q  <= 16'd0;
         len_cnt_q <= 8'd0;
         pre_cnt_q <= '0;
         phase_q   <= 1'b0;
      end else if (load) begin
         id_q      <= sel;
         hp_q      <= sel_hp;
         vol_q     <= sel_vol;
         hp_cnt_q  <= sel_hp;
         len_cnt_q <= sel_len;
         pre_cnt_q <= PRE_LOAD;
         // A zero half-period keeps the output silent for the whole effect.
         phase_q   <= (sel_hp != 16'd0);
      end else if (state_d == IDLE) begin
         hp_cnt_q  <= 16'd0;
         len_cnt_q <= 8'd0;
         pre_cnt_q <= '0;
         phase_q   <= 1'b0;
      end else begin
         if (hp_cnt_q == 16'd1) begin
            phase_q  <= ~phase_q;
            hp_cnt_q <= hp_q;
         end else if (hp_cnt_q != 16'd0) begin
            hp_cnt_q <= hp_cnt_q - 16'd1;
         end
         if (pre_cnt_q == PW'(1)) begin
            pre_cnt_q <= PRE_LOAD;
            if (len_cnt_q != 8'd0) begin
               len_cnt_q <= len_cnt_q - 8'd1;
            end
         end else if (pre_cnt_q != '0) begin
            pre_cnt_q <= pre_cnt_q - PW'(1);
         end
      end
   end

   assign active = (state_q == PLAY);
   assign cur_id = id_q;
   assign done   = done_q;
   assign duty   = (active && phase_q) ? (BIT_WIDTH + 1)'(vol_q) : '0;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Scoreboard bench for sfx_scheduler: a time-based reference model predicts each cycle's outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_sfx_scheduler;

   localparam int BW  = 8;
   localparam int PRE = 4;

   logic          clk;
   logic          rst;
   logic [3:0]    sfx_trig;
   logic [63:0]   cfg_half_period;
   logic [31:0]   cfg_len;
   logic [31:0]   cfg_volume;
   logic [BW:0]   duty;
   logic          active;
   logic [1:0]    cur_id;
   logic          done;

   sfx_scheduler #(.BIT_WIDTH(BW), .PRESCALE(PRE)) dut (
      .clk             (clk),
      .rst             (rst),
      .sfx_trig        (sfx_trig),
      .cfg_half_period (cfg_half_period),
      .cfg_len         (cfg_len),
      .cfg_volume      (cfg_volume),
      .duty            (duty),
      .active          (active),
      .cur_id          (cur_id),
      .done            (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int duty;
      bit active;
      int id;
      bit done;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: effect progress is tracked as elapsed cycles since start.
   bit [3:0] m_pend;
   bit       m_play;
   int       m_id, m_hp, m_len, m_vol, m_t;
   bit       m_done;

   function automatic int first_set(input bit [3:0] v, input int limit);
      for (int i = 0; i < limit; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic void m_start(input int g);
      m_play = 1'b1;
      m_id   = g;
      m_hp   = int'(cfg_half_period[16*g +: 16]);
      m_len  = int'(cfg_len[8*g +: 8]);
      m_vol  = int'(cfg_volume[8*g +: 8]);
      m_t    = 0;
   endfunction

   function automatic void m_reset();
      m_pend = 4'b0; m_play = 1'b0; m_id = 0; m_done = 1'b0; m_t = 0;
   endfunction

   function automatic void model_step(input bit [3:0] trig, input bit r);
      bit [3:0] set_bits;
      int g;
      if (r) begin
         m_reset();
         return;
      end
      set_bits = trig;
      m_done   = 1'b0;
      if (!m_play) begin
         g = first_set(m_pend, 4);
         if (g >= 0) begin
            m_pend[g] = 1'b0;
            if (cfg_len[8*g +: 8] != 0) m_start(g);
         end
      end else begin
         g = first_set(m_pend, m_id);
         if (g >= 0) begin
            m_pend[g] = 1'b0;
            if (cfg_len[8*g +: 8] != 0) m_start(g);
            else m_play = 1'b0;
         end else if (trig[m_id]) begin
            set_bits[m_id] = 1'b0;
            m_start(m_id);
         end else begin
            m_t++;
            if (m_t == m_len * PRE) begin
               m_play = 1'b0;
               m_done = 1'b1;
            end
         end
      end
      m_pend |= set_bits;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.active = m_play;
      e.id     = m_id;
      e.done   = m_done;
      e.duty   = (m_play && m_hp != 0 && ((m_t / m_hp) % 2 == 0)) ? m_vol : 0;
      return e;
   endfunction

   // Inputs change 1 time unit after the active edge and are held across the next one.
   task automatic step(input bit [3:0] t);
      sfx_trig = t;
      @(posedge clk);
      model_step(t, rst);
      exp_q.push_back(model_out());
      #1 sfx_trig = 4'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'b0);
   endtask

   task automatic set_cfg(input int g, input int hp, input int len, input int vol);
      cfg_half_period[16*g +: 16] = 16'(hp);
      cfg_len[8*g +: 8]           = 8'(len);
      cfg_volume[8*g +: 8]        = 8'(vol);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (int'(duty) != e.duty || active != e.active || done != e.done ||
             (e.active && int'(cur_id) != e.id)) begin
            errors++;
            $display("FAIL cycle_outputs t=%0t: got duty=%0d active=%0b id=%0d done=%0b, want duty=%0d active=%0b id=%0d done=%0b",
                     $time, duty, active, cur_id, done, e.duty, e.active, e.id, e.done);
         end
      end
   end

   task automatic async_reset_check();
      #5 rst = 1'b1;
      #1;
      checks++;
      if (duty != '0 || active != 1'b0 || done != 1'b0) begin
         errors++;
         $display("FAIL async_reset: got duty=%0d active=%0b done=%0b, want 0 0 0", duty, active, done);
      end
      m_reset();
      idle(2);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      sfx_trig = 4'b0;
      cfg_half_period = '0;
      cfg_len = '0;
      cfg_volume = '0;
      m_reset();
      idle(2);
      rst = 1'b0;
      idle(2);

      // Basic square wave.
      set_cfg(2, 3, 2, 200);
      step(4'b0100);
      idle(12);

      // Preemption of a long low-priority effect.
      set_cfg(3, 5, 10, 77);
      set_cfg(0, 2, 1, 9);
      step(4'b1000);
      idle(6);
      step(4'b0001);
      idle(10);

      // Simultaneous triggers queue by priority.
      set_cfg(1, 1, 1, 33);
      set_cfg(3, 2, 2, 150);
      step(4'b1010);
      idle(18);

      // Zero length and zero half-period.
      set_cfg(1, 4, 0, 99);
      step(4'b0010);
      idle(4);
      set_cfg(2, 0, 3, 123);
      step(4'b0100);
      idle(16);

      // Restart mid-effect.
      set_cfg(2, 3, 2, 200);
      step(4'b0100);
      idle(3);
      step(4'b0100);
      idle(12);

      // Asynchronous reset mid-effect with a pending lower-priority request.
      set_cfg(3, 5, 10, 77);
      set_cfg(1, 2, 2, 44);
      step(4'b1000);
      idle(3);
      step(4'b0010);
      idle(2);
      async_reset_check();
      idle(6);

      // Randomized traffic with cfg churn during playback.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            set_cfg($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3),
                    $urandom_range(0, 255));
         end
         if ($urandom_range(0, 199) == 0) begin
            async_reset_check();
         end else begin
            step(($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0);
         end
      end
      idle(3);
      @(posedge clk);
      #6;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
